// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter
// Round-robin arbiter that shares one rs232 transmitter among four requesters.
// A grant is held for a whole message, ending on the byte flagged req_last, so
// messages from different requesters never interleave on the line.
// Each accepted byte is forwarded as a one-cycle tx_flag strobe with tx_data,
// and the requester sees an ack pulse on the same cycle.
// Optional feature macro: RS232_TX_ARB_WATCHDOG_EN
//   defined     - a mid-message gap watchdog drops an owner that stays silent
//                 for GAP_CYC cycles and pulses timeout_err.
//   not defined - no gap counter; the owner keeps the line until its last byte.
module rs232_tx_arbiter #(
    parameter int clk_freq = 50000000,
    parameter int uart_bps = 9600,
    parameter int gap_bits = 20
) (
    input  logic        system_clk,
    input  logic        system_rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    input  logic        tx_busy,
    output logic [3:0]  grant,
    output logic [3:0]  ack,
    output logic [7:0]  tx_data,
    output logic        tx_flag,
    output logic        timeout_err
);

    // Mid-message idle limit in system clock cycles.
    localparam int GAP_CYC = (clk_freq / uart_bps) * gap_bits;
    localparam int GAP_W   = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t      state_reg;
    logic [1:0]  ptr_reg;
    logic [1:0]  owner_reg;
    logic        last_reg;
    logic [3:0]  grant_reg;
    logic [3:0]  ack_reg;
    logic [7:0]  tx_data_reg;
    logic        tx_flag_reg;

    logic [7:0]  lane_bytes [4];
    logic        win_valid;
    logic [1:0]  win_idx;

    // Split the packed request bus into per-requester byte lanes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_bytes[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Round-robin pick: first requester at or above ptr_reg, wrapping modulo 4.
    // Scanning from the far end down leaves the nearest candidate as the winner.
    always_comb begin
        logic [1:0] cand;
        cand      = '0;
        win_valid = 1'b0;
        win_idx   = ptr_reg;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_reg + 2'(k);
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef RS232_TX_ARB_WATCHDOG_EN
    logic [GAP_W-1:0] gap_cnt_reg;
    logic             timeout_reg;

    // Arbitration FSM with the gap watchdog; all outputs registered here.
    always_ff @(posedge system_clk) begin
        if (system_rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            owner_reg   <= '0;
            last_reg    <= 1'b0;
            grant_reg   <= '0;
            ack_reg     <= '0;
            tx_data_reg <= '0;
            tx_flag_reg <= 1'b0;
            gap_cnt_reg <= '0;
            timeout_reg <= 1'b0;
        end else begin
            ack_reg     <= '0;
            tx_flag_reg <= 1'b0;
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (win_valid && !tx_busy) begin
                        owner_reg   <= win_idx;
                        grant_reg   <= 4'b0001 << win_idx;
                        gap_cnt_reg <= '0;
                        state_reg   <= SEND;
                    end
                end
                SEND: begin
                    if (req[owner_reg] && !tx_busy) begin
                        tx_data_reg <= lane_bytes[owner_reg];
                        tx_flag_reg <= 1'b1;
                        ack_reg     <= 4'b0001 << owner_reg;
                        last_reg    <= req_last[owner_reg];
                        gap_cnt_reg <= '0;
                        state_reg   <= WAIT_HI;
                    end else if (!req[owner_reg]) begin
                        // Saturating count of silent cycles; firing on the
                        // step that reaches the limit drops the owner.
                        if (gap_cnt_reg != GAP_MAX) begin
                            gap_cnt_reg <= gap_cnt_reg + 1'b1;
                        end
                        if (gap_cnt_reg + 1'b1 == GAP_MAX) begin
                            timeout_reg <= 1'b1;
                            grant_reg   <= '0;
                            ptr_reg     <= owner_reg + 2'd1;
                            state_reg   <= IDLE;
                        end
                    end
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state_reg <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (last_reg) begin
                            grant_reg <= '0;
                            ptr_reg   <= owner_reg + 2'd1;
                            state_reg <= IDLE;
                        end else begin
                            state_reg <= SEND;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign timeout_err = timeout_reg;
`else
    // Keeps the timing parameters referenced when no watchdog is built.
    logic [GAP_W-1:0] unused_gap_limit;
    assign unused_gap_limit = GAP_MAX;

    // Arbitration FSM without watchdog; the owner holds until its last byte.
    always_ff @(posedge system_clk) begin
        if (system_rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            owner_reg   <= '0;
            last_reg    <= 1'b0;
            grant_reg   <= '0;
            ack_reg     <= '0;
            tx_data_reg <= '0;
            tx_flag_reg <= 1'b0;
        end else begin
            ack_reg     <= '0;
            tx_flag_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (win_valid && !tx_busy) begin
                        owner_reg <= win_idx;
                        grant_reg <= 4'b0001 << win_idx;
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    if (req[owner_reg] && !tx_busy) begin
                        tx_data_reg <= lane_bytes[owner_reg];
                        tx_flag_reg <= 1'b1;
                        ack_reg     <= 4'b0001 << owner_reg;
                        last_reg    <= req_last[owner_reg];
                        state_reg   <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state_reg <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (last_reg) begin
                            grant_reg <= '0;
                            ptr_reg   <= owner_reg + 2'd1;
                            state_reg <= IDLE;
                        end else begin
                            state_reg <= SEND;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign timeout_err = 1'b0;
`endif

    assign grant   = grant_reg;
    assign ack     = ack_reg;
    assign tx_data = tx_data_reg;
    assign tx_flag = tx_flag_reg;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Testbench for rs232_tx_arbiter: directed requester scenarios, a simple
// transmitter model, and a scoreboard that checks every tx_flag/ack against
// the expected byte order. Watchdog expectations follow RS232_TX_ARB_WATCHDOG_EN.
module tb_rs232_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic        tx_busy;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [7:0]  tx_data;
    logic        tx_flag;
    logic        timeout_err;

    logic        lane_req  [4];
    logic [7:0]  lane_data [4];
    logic        lane_last [4];

    int checks = 0;
    int passes = 0;

    typedef struct {
        int         lane;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    int   busy_cnt;
    logic force_busy;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pack
            assign req[gi]             = lane_req[gi];
            assign req_data[8*gi +: 8] = lane_data[gi];
            assign req_last[gi]        = lane_last[gi];
        end
    endgenerate

    rs232_tx_arbiter #(
        .clk_freq(1000),
        .uart_bps(100),
        .gap_bits(2)
    ) dut (
        .system_clk (clk),
        .system_rst (rst),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .tx_busy    (tx_busy),
        .grant      (grant),
        .ack        (ack),
        .tx_data    (tx_data),
        .tx_flag    (tx_flag),
        .timeout_err(timeout_err)
    );

    // Transmitter model: busy rises one cycle after tx_flag, stays high 10 cycles.
    always @(posedge clk) begin
        if (rst) busy_cnt <= 0;
        else if (tx_flag) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) || force_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Monitor: pop one expected byte per tx_flag and compare data and ack lane.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_flag) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL sb_unexpected_flag: got tx_data %0h ack %b, required no tx_flag", tx_data, ack);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_data", {24'h0, tx_data}, {24'h0, e.data});
                    check("sb_ack", {28'h0, ack}, 32'd1 << e.lane);
                    $display("tx byte %02h lane ack %b (expected lane %0d)", tx_data, ack, e.lane);
                end
            end else if (ack != 4'b0) begin
                check("ack_without_flag", {28'h0, ack}, 32'h0);
            end
        end
    end

    task automatic push(input int l, input logic [7:0] d);
        exp_t e;
        e.lane = l;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic set_lane(input int l, input logic [7:0] d, input logic last);
        lane_data[l] = d;
        lane_last[l] = last;
        lane_req[l]  = 1'b1;
    endtask

    task automatic wait_ack(input int l);
        int n;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (ack[l]) break;
            n++;
        end
        if (n >= 300) begin
            checks++;
            $display("FAIL ack_timeout: lane %0d got no ack, required ack within 300 cycles", l);
        end
        lane_req[l] = 1'b0;
    endtask

    task automatic send_byte(input int l, input logic [7:0] d, input logic last);
        set_lane(l, d, last);
        wait_ack(l);
    endtask

    task automatic wait_busy_fall();
        int n;
        n = 0;
        while (n < 50 && !tx_busy) begin @(negedge clk); n++; end
        while (n < 100 && tx_busy) begin @(negedge clk); n++; end
        if (n >= 100) begin
            checks++;
            $display("FAIL busy_fall_timeout: tx_busy %b, required a rise then a fall", tx_busy);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 300 && (tx_busy || grant != 4'b0)) begin @(negedge clk); n++; end
        if (n >= 300) begin
            checks++;
            $display("FAIL idle_timeout: grant %b busy %b, required both 0", grant, tx_busy);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin #2000000; $display("FAIL global_timeout: simulation did not finish"); $fatal(1); end

    initial begin
        for (int i = 0; i < 4; i++) begin
            lane_req[i]  = 1'b0;
            lane_data[i] = 8'h00;
            lane_last[i] = 1'b0;
        end
        force_busy = 1'b0;
        do_reset();

        // Reset values
        @(negedge clk);
        check("rst_grant", {28'h0, grant}, 32'h0);
        check("rst_ack", {28'h0, ack}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_tx_flag", {31'h0, tx_flag}, 32'h0);
        check("rst_timeout", {31'h0, timeout_err}, 32'h0);

        // Three-byte message from requester 1, with latency checks on byte one
        push(1, 8'hA1); push(1, 8'hA2); push(1, 8'hA3);
        @(posedge clk); #1;
        fork
            send_byte(1, 8'hA1, 1'b0);
            begin
                @(posedge clk); @(negedge clk);
                check("lat_grant_n1", {28'h0, grant}, 32'h2);
                check("lat_noflag_n1", {31'h0, tx_flag}, 32'h0);
                @(negedge clk);
                check("lat_flag_n2", {31'h0, tx_flag}, 32'h1);
            end
        join
        send_byte(1, 8'hA2, 1'b0);
        check("msg_grant_b2", {28'h0, grant}, 32'h2);
        send_byte(1, 8'hA3, 1'b1);
        check("msg_grant_b3", {28'h0, grant}, 32'h2);
        wait_busy_fall();
        check("msg_grant_at_fall", {28'h0, grant}, 32'h2);
        @(negedge clk);
        check("msg_grant_release", {28'h0, grant}, 32'h0);

        // Simultaneous requests 0 and 2 after reset, then again with ptr = 3
        do_reset();
        push(0, 8'h10); push(2, 8'h30); push(0, 8'h10); push(2, 8'h30);
        @(posedge clk); #1;
        fork
            send_byte(0, 8'h10, 1'b1);
            send_byte(2, 8'h30, 1'b1);
        join
        wait_idle();
        @(posedge clk); #1;
        fork
            send_byte(0, 8'h10, 1'b1);
            send_byte(2, 8'h30, 1'b1);
        join
        wait_idle();

        // Requester 3 arrives mid-message and must wait for requester 1
        push(1, 8'hA1); push(1, 8'hA2); push(1, 8'hA3); push(3, 8'h77);
        @(posedge clk); #1;
        fork
            begin
                send_byte(1, 8'hA1, 1'b0);
                send_byte(1, 8'hA2, 1'b0);
                send_byte(1, 8'hA3, 1'b1);
            end
            begin
                int n;
                n = 0;
                while (n < 300 && !(ack[1] && tx_data == 8'hA2)) begin @(negedge clk); n++; end
                if (n >= 300) begin
                    checks++;
                    $display("FAIL mid_wait_timeout: second byte of lane 1 never seen, required it");
                end
                send_byte(3, 8'h77, 1'b1);
            end
        join
        wait_idle();

        // tx_busy held high blocks granting
        force_busy = 1'b1;
        push(2, 8'h55);
        set_lane(2, 8'h55, 1'b1);
        repeat (6) @(negedge clk);
        check("busy_block_grant", {28'h0, grant}, 32'h0);
        @(posedge clk); #1 force_busy = 1'b0;
        @(posedge clk); @(negedge clk);
        check("busy_release_grant", {28'h0, grant}, 32'h4);
        wait_ack(2);
        wait_idle();

        // Owner goes silent after a non-last byte
        push(0, 8'h01);
        send_byte(0, 8'h01, 1'b0);
        wait_busy_fall();
`ifdef RS232_TX_ARB_WATCHDOG_EN
        begin
            int early;
            early = 0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (timeout_err) early++;
            end
            check("wd_no_early_timeout", early, 0);
            @(negedge clk);
            check("wd_timeout_pulse", {31'h0, timeout_err}, 32'h1);
            check("wd_grant_dropped", {28'h0, grant}, 32'h0);
            @(negedge clk);
            check("wd_timeout_one_cycle", {31'h0, timeout_err}, 32'h0);
        end
`else
        begin
            int seen;
            seen = 0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (timeout_err) seen++;
            end
            check("nowd_no_timeout", seen, 0);
            check("nowd_grant_held", {28'h0, grant}, 32'h1);
            push(0, 8'h02);
            send_byte(0, 8'h02, 1'b1);
            wait_busy_fall();
            @(negedge clk);
            check("nowd_grant_release", {28'h0, grant}, 32'h0);
        end
`endif
        wait_idle();

        // Reset while in WAIT_LO, with requesters 0 and 1 pending
        push(2, 8'h66);
        send_byte(2, 8'h66, 1'b0);
        begin
            int n;
            n = 0;
            while (n < 50 && !tx_busy) begin @(negedge clk); n++; end
        end
        @(negedge clk);
        set_lane(0, 8'h44, 1'b1);
        set_lane(1, 8'h45, 1'b1);
        push(0, 8'h44); push(1, 8'h45);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_grant", {28'h0, grant}, 32'h0);
        check("midrst_ack", {28'h0, ack}, 32'h0);
        check("midrst_tx_data", {24'h0, tx_data}, 32'h0);
        check("midrst_tx_flag", {31'h0, tx_flag}, 32'h0);
        check("midrst_timeout", {31'h0, timeout_err}, 32'h0);
        @(negedge clk);
        check("midrst_regrant", {28'h0, grant}, 32'h1);
        wait_ack(0);
        wait_ack(1);
        wait_idle();

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rs232_tx_arbiter.md
# rs232_tx_arbiter

Round-robin arbiter that shares one rs232 UART transmitter among four requesters. It grants the line to one requester at a time and forwards that requester's bytes to the transmitter as a single-cycle `tx_flag` strobe plus `tx_data`. The grant holds for a whole message, so messages never interleave. It sits between the application/loopback logic (for example, the rx `po_data`/`po_flag` path) and the serial tx engine.

## Interface
- `clk_freq`, default 50000000: system clock frequency in Hz.
- `uart_bps`, default 9600: line baud rate.
- `gap_bits`, default 20: mid-message idle limit, in bit periods. `GAP_CYC = (clk_freq/uart_bps)*gap_bits`, which is 104160 at the defaults.

- `system_clk`  in  1  system clock.
- `system_rst`  in  1  reset; synchronous, active-high.
- `req`  in  4  `req[i]` high means requester i has a valid byte on its lane.
- `req_data`  in  32  byte lane i is `req_data[8i+7:8i]`.
- `req_last`  in  4  `req_last[i]` high means lane i's byte is the last of its message.
- `tx_busy`  in  1  transmitter is shifting a frame.
- `grant`  out  4  one-hot current owner; 0 when no owner.
- `ack`  out  4  one-cycle pulse; lane i's byte was accepted.
- `tx_data`  out  8  byte handed to the transmitter.
- `tx_flag`  out  1  one-cycle start strobe to the transmitter.
- `timeout_err`  out  1  one-cycle pulse; the owner was dropped by the watchdog.

## Operation
- States:
  - IDLE: no owner.
  - SEND: owner granted, waiting for a byte.
  - WAIT_HI: waiting for `tx_busy` to rise.
  - WAIT_LO: waiting for `tx_busy` to fall.
- IDLE:
  - If `req != 0` and `tx_busy = 0`, the winner is the first set `req` bit scanning from pointer `ptr` upward (mod 4).
  - Register the winner into `grant`, then go to SEND.
  - If `tx_busy = 1`, grant nothing.
- SEND:
  - When `req[owner] = 1` and `tx_busy = 0`: load `tx_data` from the owner's lane, pulse `tx_flag` and `ack[owner]`, latch `req_last[owner]` into `last_q`, clear the gap counter, and go to WAIT_HI.
- WAIT_HI → WAIT_LO on `tx_busy = 1`.
- WAIT_LO on `tx_busy = 0`:
  - If `last_q = 1`: `grant` ← 0, `ptr` ← owner+1 (wraps 3→0), go to IDLE.
  - Otherwise go back to SEND.
- Requester contract:
  - Hold `req`, the lane data and `req_last` stable until `ack`.
  - The lane may change on the cycle after `ack`.
  - Bytes from a non-owner are ignored; that requester just waits.
- A single-byte message is one byte with `req_last = 1`.
- Gap watchdog: in SEND, the counter increments on every cycle with `req[owner] = 0`. When it reaches `GAP_CYC`:
  - pulse `timeout_err` and set `grant` ← 0;
  - `ptr` ← owner+1, go to IDLE;
  - no `tx_flag` is issued.
- Counter width is `$clog2(GAP_CYC+1)`. It saturates and never wraps.

## Timing
- Reset values:
  - `grant`, `ack`, `tx_data`, `tx_flag`, `timeout_err` = 0;
  - `ptr` = 0, state = IDLE, gap counter = 0, `last_q` = 0.
- Every output is registered.
- Latency, with `req` rising in IDLE at cycle n: `grant` valid at n+1; `tx_flag` and `ack` at n+2 at the earliest.
- `tx_flag` and `ack` are asserted in the same cycle and last exactly one cycle. `tx_data` holds its value until the next load.
- Simultaneous requests: the rotating pointer alone decides. After reset, requester 0 has priority.
- New requests arriving during a message have no effect until the message ends.
- A requester that asserts `req` on the same cycle the grant releases competes in the next IDLE evaluation (one cycle later).
- `tx_busy` never rising after `tx_flag`: the block stays in WAIT_HI. That is a transmitter fault and is out of scope here.
- Reset mid-operation:
  - Everything returns to reset values on the next edge.
  - Any `tx_flag` or `ack` pulse in flight is cut off and never reissued.

## Configuration
- `RS232_TX_ARB_WATCHDOG_EN` defined: the gap watchdog and `timeout_err` operate as described above.
- Not defined:
  - no gap counter is built; `timeout_err` is tied to 0;
  - the owner keeps the grant indefinitely until its `req_last` byte completes.

## Test plan
- Run with the transmitter model: `tx_busy` rises 1 cycle after `tx_flag` and stays high 10 cycles.
- After reset, `req[1]` sends bytes 0xA1, 0xA2, 0xA3 with `req_last` on 0xA3 → three `tx_flag` pulses carrying 0xA1/0xA2/0xA3 in order. `grant` = 4'b0010 throughout and goes to 0 one cycle after the third `tx_busy` fall.
- `req[0]` and `req[2]` rise on the same cycle after reset, each sending a one-byte message (0x10 / 0x30) → 0x10 goes first, then 0x30. Repeat both requests → 0x10 first again, because `ptr` = 3 scans 3→0.
- `req[3]` (0x77) asserts during the second byte of `req[1]`'s message → no `ack[3]` until `req[1]`'s last byte completes. 0x77 is then the next `tx_flag` byte.
- `RS232_TX_ARB_WATCHDOG_EN` defined, parameters `clk_freq` = 1000, `uart_bps` = 100, `gap_bits` = 2 (so `GAP_CYC` = 20). The owner drops `req` after a non-last byte → `timeout_err` pulses once 20 cycles after the return to SEND, `grant` = 0, and no extra `tx_flag`. Without the macro → `grant` is held and `timeout_err` stays 0.
- `tx_busy` is forced high while `req[2]` is asserted → `grant` stays 0. Releasing `tx_busy` → `grant` = 4'b0100 one cycle later.
- Assert `system_rst` for 1 cycle while in WAIT_LO → next cycle all outputs are 0 and state is IDLE. A pending `req[0]` is then granted as after a fresh reset.
